// File: rtl/toy_fetch_resp_if.sv
// Fetch request/response handshake bundle between an instruction fetcher
// (master) and the line-fetch responder (slave).
interface toy_fetch_resp_if #(
    parameter int ADDR_WIDTH       = 32,
    parameter int ID_WIDTH         = 16,
    parameter int FETCH_DATA_WIDTH = 128
);
    logic                        fetch_mem_req_vld;
    logic                        fetch_mem_req_rdy;
    logic [ADDR_WIDTH-1:0]       fetch_mem_req_addr;
    logic [ID_WIDTH-1:0]         fetch_mem_req_entry_id;
    logic                        fetch_mem_ack_vld;
    logic                        fetch_mem_ack_rdy;
    logic [FETCH_DATA_WIDTH-1:0] fetch_mem_ack_data;
    logic [ID_WIDTH-1:0]         fetch_mem_ack_entry_id;

    modport master (
        output fetch_mem_req_vld, fetch_mem_req_addr, fetch_mem_req_entry_id,
        output fetch_mem_ack_rdy,
        input  fetch_mem_req_rdy, fetch_mem_ack_vld, fetch_mem_ack_data,
        input  fetch_mem_ack_entry_id
    );

    modport slave (
        input  fetch_mem_req_vld, fetch_mem_req_addr, fetch_mem_req_entry_id,
        input  fetch_mem_ack_rdy,
        output fetch_mem_req_rdy, fetch_mem_ack_vld, fetch_mem_ack_data,
        output fetch_mem_ack_entry_id
    );
endinterface

// File: rtl/toy_fetch_resp.sv
// Line-fetch responder: turns one fetch request into BEATS sequential SRAM
// reads within the aligned line and returns the assembled line with its tag.
//
// state | meaning
// IDLE  | ready for a request (req_rdy=1)
// READ  | issuing one SRAM read per cycle, beat = cnt
// DRAIN | waiting for the last beat's read data
// ACK   | line valid, held until the requester takes it
module toy_fetch_resp #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int BEATS          = 4,
    parameter int ID_WIDTH       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    toy_fetch_resp_if.slave             fetch,
    output logic                        inst_mem_en,
    output logic [ADDR_WIDTH-1:0]       inst_mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0]   inst_mem_rd_data,
    output logic                        inst_mem_wr_en,
    output logic [MEM_DATA_WIDTH-1:0]   inst_mem_wr_data,
    output logic [MEM_DATA_WIDTH/8-1:0] inst_mem_wr_byte_en
);
    localparam int FETCH_DATA_WIDTH = BEATS * MEM_DATA_WIDTH;
    localparam int CNT_W            = $clog2(BEATS);
    localparam int WORD_LSB         = $clog2(MEM_DATA_WIDTH / 8);
    localparam int LINE_LSB         = WORD_LSB + CNT_W;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << LINE_LSB) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, ACK} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]       base_q;
    logic [ID_WIDTH-1:0]         id_q;
    logic                        rd_pend_q;
    logic [CNT_W-1:0]            rd_idx_q;
    logic [FETCH_DATA_WIDTH-1:0] ack_data_q;
    logic                        accept;

    assign inst_mem_wr_en         = 1'b0;
    assign inst_mem_wr_data       = '0;
    assign inst_mem_wr_byte_en    = '0;
    assign fetch.fetch_mem_ack_data     = ack_data_q;
    assign fetch.fetch_mem_ack_entry_id = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        cnt_d                   = cnt_q;
        accept                  = 1'b0;
        fetch.fetch_mem_req_rdy = 1'b0;
        fetch.fetch_mem_ack_vld = 1'b0;
        inst_mem_en             = 1'b0;
        inst_mem_addr           = '0;
        case (state_q)
            IDLE: begin
                fetch.fetch_mem_req_rdy = 1'b1;
                if (fetch.fetch_mem_req_vld) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                inst_mem_en = 1'b1;
                // base has the line-offset bits cleared, so OR-ing the beat
                // offset can never carry into the next line
                inst_mem_addr = base_q | (ADDR_WIDTH'(cnt_q) << WORD_LSB);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BEAT) state_d = DRAIN;
            end
            DRAIN: state_d = ACK;
            ACK: begin
                fetch.fetch_mem_ack_vld = 1'b1;
                if (fetch.fetch_mem_ack_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            id_q   <= '0;
        end else if (accept) begin
            base_q <= fetch.fetch_mem_req_addr & LINE_MASK;
            id_q   <= fetch.fetch_mem_req_entry_id;
        end
    end

    // SRAM data returns one cycle after the strobe; remember which beat it is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_idx_q   <= '0;
            ack_data_q <= '0;
        end else begin
            rd_pend_q <= inst_mem_en;
            rd_idx_q  <= cnt_q;
            if (rd_pend_q)
                ack_data_q[int'(rd_idx_q) * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= inst_mem_rd_data;
        end
    end
endmodule

// File: tb/tb_toy_fetch_resp.sv
// Directed bench for toy_fetch_resp with a cycle-timeline reference model
// and literal spot checks on the documented scenarios.
module tb_toy_fetch_resp;
    localparam int AW    = 32;
    localparam int MDW   = 32;
    localparam int BEATS = 4;
    localparam int IDW   = 16;
    localparam int FDW   = BEATS * MDW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic            inst_mem_en;
    logic [AW-1:0]   inst_mem_addr;
    logic [MDW-1:0]  inst_mem_rd_data = '0;
    logic            inst_mem_wr_en;
    logic [MDW-1:0]  inst_mem_wr_data;
    logic [MDW/8-1:0] inst_mem_wr_byte_en;

    int checks = 0;
    int failures = 0;

    toy_fetch_resp_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IDW), .FETCH_DATA_WIDTH(FDW)) fif ();

    toy_fetch_resp #(.ADDR_WIDTH(AW), .MEM_DATA_WIDTH(MDW), .BEATS(BEATS), .ID_WIDTH(IDW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetch               (fif.slave),
        .inst_mem_en         (inst_mem_en),
        .inst_mem_addr       (inst_mem_addr),
        .inst_mem_rd_data    (inst_mem_rd_data),
        .inst_mem_wr_en      (inst_mem_wr_en),
        .inst_mem_wr_data    (inst_mem_wr_data),
        .inst_mem_wr_byte_en (inst_mem_wr_byte_en)
    );

    always #5 clk = ~clk;

    function automatic logic [MDW-1:0] memf(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [FDW-1:0] line_of(input logic [AW-1:0] base);
        logic [FDW-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k*MDW +: MDW] = memf(base + AW'(k * (MDW / 8)));
        return l;
    endfunction

    task automatic chk(input string nm, input logic [FDW-1:0] act, input logic [FDW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // SRAM: data for the strobed address appears one cycle later
    always @(posedge clk)
        inst_mem_rd_data <= inst_mem_en ? memf(inst_mem_addr) : 32'hDEAD_BEEF;

    // Timeline model: after accept in cycle T, reads on T+1..T+BEATS,
    // a silent cycle, then the line is offered from T+BEATS+2 until taken.
    bit            m_busy = 0;
    int            m_age  = 0;
    logic [AW-1:0] m_base;
    logic [IDW-1:0] m_id;

    always @(negedge clk) begin
        chk("wr_en", inst_mem_wr_en, 0);
        chk("wr_side", {inst_mem_wr_data, inst_mem_wr_byte_en}, 0);
        if (!rst_n) begin
            chk("rst_ack_vld", fif.fetch_mem_ack_vld, 0);
            chk("rst_mem_en", inst_mem_en, 0);
            chk("rst_mem_addr", inst_mem_addr, 0);
            chk("rst_ack_data", fif.fetch_mem_ack_data, 0);
            chk("rst_ack_id", fif.fetch_mem_ack_entry_id, 0);
            m_busy = 0;
        end else if (!m_busy) begin
            chk("m_idle_rdy", fif.fetch_mem_req_rdy, 1);
            chk("m_idle_en", inst_mem_en, 0);
            chk("m_idle_vld", fif.fetch_mem_ack_vld, 0);
            if (fif.fetch_mem_req_vld) begin
                m_busy = 1;
                m_age  = 1;
                m_base = fif.fetch_mem_req_addr & ~AW'(FDW / 8 - 1);
                m_id   = fif.fetch_mem_req_entry_id;
            end
        end else begin
            chk("m_busy_rdy", fif.fetch_mem_req_rdy, 0);
            if (m_age <= BEATS) begin
                chk("m_read_en", inst_mem_en, 1);
                chk("m_read_addr", inst_mem_addr, m_base + AW'((m_age - 1) * (MDW / 8)));
                chk("m_read_vld", fif.fetch_mem_ack_vld, 0);
            end else if (m_age == BEATS + 1) begin
                chk("m_drain_en", inst_mem_en, 0);
                chk("m_drain_vld", fif.fetch_mem_ack_vld, 0);
            end else begin
                chk("m_ack_en", inst_mem_en, 0);
                chk("m_ack_vld", fif.fetch_mem_ack_vld, 1);
                chk("m_ack_data", fif.fetch_mem_ack_data, line_of(m_base));
                chk("m_ack_id", fif.fetch_mem_ack_entry_id, m_id);
            end
            if (m_age >= BEATS + 2 && fif.fetch_mem_ack_rdy) m_busy = 0;
            else m_age++;
        end
    end

    // Presents a request for one cycle; the DUT must be idle. Returns in T+1.
    task automatic issue(input logic [AW-1:0] a, input logic [IDW-1:0] id);
        @(posedge clk); #1;
        fif.fetch_mem_req_vld      = 1'b1;
        fif.fetch_mem_req_addr     = a;
        fif.fetch_mem_req_entry_id = id;
        @(posedge clk); #1;
        fif.fetch_mem_req_vld = 1'b0;
    endtask

    task automatic run_single(input logic [AW-1:0] a, input logic [IDW-1:0] id,
                              input logic [AW-1:0] line_base, input logic [FDW-1:0] line);
        issue(a, id);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 4) chk("lit_addr", inst_mem_addr, line_base + AW'(4 * (k - 1)));
            if (k == 6) begin
                chk("lit_vld", fif.fetch_mem_ack_vld, 1);
                chk("lit_data", fif.fetch_mem_ack_data, line);
                chk("lit_id", fif.fetch_mem_ack_entry_id, id);
            end
            if (k == 5 || k == 7) chk("lit_vld_lo", fif.fetch_mem_ack_vld, 0);
        end
    endtask

    initial begin
        fif.fetch_mem_req_vld      = 1'b0;
        fif.fetch_mem_req_addr     = '0;
        fif.fetch_mem_req_entry_id = '0;
        fif.fetch_mem_ack_rdy      = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", fif.fetch_mem_req_rdy, 1);

        // single fetch, unaligned address within the line
        run_single(32'h0000_1004, 16'h002A, 32'h0000_1000,
                   128'h100CEFF3_1008EFF7_1004EFFB_1000EFFF);

        // backpressure: line held for 10 cycles
        @(posedge clk); #1 fif.fetch_mem_ack_rdy = 1'b0;
        issue(32'h0000_2000, 16'h0033);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_vld", fif.fetch_mem_ack_vld, 1);
            chk("bp_id", fif.fetch_mem_ack_entry_id, 16'h0033);
            chk("bp_rdy", fif.fetch_mem_req_rdy, 0);
            chk("bp_en", inst_mem_en, 0);
        end
        @(posedge clk); #1 fif.fetch_mem_ack_rdy = 1'b1;
        @(negedge clk);
        chk("bp_hs_vld", fif.fetch_mem_ack_vld, 1);
        @(negedge clk);
        chk("bp_after_vld", fif.fetch_mem_ack_vld, 0);
        chk("bp_after_rdy", fif.fetch_mem_req_rdy, 1);

        // back-to-back with req_vld held high
        @(posedge clk); #1;
        fif.fetch_mem_req_vld      = 1'b1;
        fif.fetch_mem_req_addr     = 32'h0000_3000;
        fif.fetch_mem_req_entry_id = 16'h0001;
        @(posedge clk); #1;
        fif.fetch_mem_req_entry_id = 16'h0002;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 6) chk("b2b_id1", fif.fetch_mem_ack_entry_id, 16'h0001);
            if (k == 6) chk("b2b_vld1", fif.fetch_mem_ack_vld, 1);
            if (k == 7) chk("b2b_accept2", fif.fetch_mem_req_rdy, 1);
            if (k == 8) chk("b2b_addr2", inst_mem_addr, 32'h0000_3000);
            if (k == 13) chk("b2b_id2", fif.fetch_mem_ack_entry_id, 16'h0002);
            if (k == 13) chk("b2b_vld2", fif.fetch_mem_ack_vld, 1);
        end
        @(posedge clk); #1 fif.fetch_mem_req_vld = 1'b0;
        @(negedge clk);
        chk("b2b_idle_vld", fif.fetch_mem_ack_vld, 0);

        // top of address space: no wrap to zero
        run_single(32'hFFFF_FFF8, 16'h0077, 32'hFFFF_FFF0,
                   128'hFFFC0003_FFF80007_FFF4000B_FFF0000F);

        // stray req_vld during READ is ignored
        issue(32'h0000_4010, 16'h0044);
        fif.fetch_mem_req_vld      = 1'b1;
        fif.fetch_mem_req_addr     = 32'h0000_9000;
        fif.fetch_mem_req_entry_id = 16'h0055;
        @(negedge clk);
        chk("stray_rdy", fif.fetch_mem_req_rdy, 0);
        @(posedge clk); #1 fif.fetch_mem_req_vld = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) chk("stray_id", fif.fetch_mem_ack_entry_id, 16'h0044);
            if (k == 7) chk("stray_vld_lo", fif.fetch_mem_ack_vld, 0);
            if (k == 8) chk("stray_no_burst", inst_mem_en, 0);
        end

        // reset after two READ beats
        issue(32'h0000_5000, 16'h0066);
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_data", fif.fetch_mem_ack_data, 0);
            chk("mid_rst_en", inst_mem_en, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_abort_vld", fif.fetch_mem_ack_vld, 0);
            chk("post_abort_en", inst_mem_en, 0);
            chk("post_abort_rdy", fif.fetch_mem_req_rdy, 1);
        end

        run_single(32'h0000_1004, 16'h002A, 32'h0000_1000,
                   128'h100CEFF3_1008EFF7_1004EFFB_1000EFFF);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/toy_fetch_resp.md
TOY_FETCH_RESP -- requirements
Module: toy_fetch_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 32, meaning instruction-memory word width (power of two, >=8).
REQ-003 SHALL have parameter BEATS, default 4, meaning words per fetch line (power of two, >=2); FETCH_DATA_WIDTH = BEATS*MEM_DATA_WIDTH.
REQ-004 SHALL have parameter ID_WIDTH, default 16, meaning fetch entry-id width, carried through unmodified.
REQ-005 clk  input  1  clock; all state on posedge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 fetch_mem_req_vld  input  1  fetch request valid.
REQ-008 fetch_mem_req_rdy  output  1  request accepted when vld&&rdy.
REQ-009 fetch_mem_req_addr  input  ADDR_WIDTH  fetch byte address.
REQ-010 fetch_mem_req_entry_id  input  ID_WIDTH  requester tag.
REQ-011 fetch_mem_ack_vld  output  1  response valid.
REQ-012 fetch_mem_ack_rdy  input  1  response consumed when vld&&rdy.
REQ-013 fetch_mem_ack_data  output  FETCH_DATA_WIDTH  fetched line.
REQ-014 fetch_mem_ack_entry_id  output  ID_WIDTH  tag of the request being answered.
REQ-015 inst_mem_en  output  1  SRAM read strobe.
REQ-016 inst_mem_addr  output  ADDR_WIDTH  SRAM byte address.
REQ-017 inst_mem_rd_data  input  MEM_DATA_WIDTH  SRAM read data, valid exactly one cycle after inst_mem_en.
REQ-018 inst_mem_wr_en, inst_mem_wr_data, inst_mem_wr_byte_en  output  1 / MEM_DATA_WIDTH / MEM_DATA_WIDTH/8  tied to zero (read-only port).

Function
REQ-019 SHALL implement FSM states IDLE, READ, DRAIN, ACK; fetch_mem_req_rdy = 1 only in IDLE.
REQ-020 On accept in IDLE (cycle T): latch line base = req_addr with low log2(FETCH_DATA_WIDTH/8) bits cleared, latch entry_id, clear beat counter, go READ.
REQ-021 In READ: inst_mem_en=1, inst_mem_addr = base + cnt*(MEM_DATA_WIDTH/8) (mod 2^ADDR_WIDTH), cnt increments each cycle; after beat BEATS-1 go DRAIN. Reads occupy cycles T+1..T+BEATS.
REQ-022 Read data of beat k (arriving the cycle after its issue) SHALL be captured into ack_data[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH].
REQ-023 DRAIN lasts one cycle, captures the last beat, goes ACK; fetch_mem_ack_vld asserted from cycle T+BEATS+2.
REQ-024 In ACK: ack_vld, ack_data, ack_entry_id held stable until ack_rdy=1; on handshake go IDLE, ack_vld deasserts next cycle.
REQ-025 inst_mem_en SHALL be 0 in IDLE, DRAIN and ACK; at most one request outstanding.
REQ-026 req_vld while not IDLE SHALL be ignored (not accepted, no side effect); requester holds it per vld/rdy rules.
REQ-027 Back-to-back: next request accepted earliest one cycle after ack handshake (IDLE cycle).
REQ-028 Line address increment SHALL not carry out of the line: beat addresses stay within the aligned line.

Reset
REQ-029 On rst_n low, immediately: state IDLE, cnt 0, fetch_mem_ack_vld 0, inst_mem_en 0, ack_data 0, ack_entry_id 0, inst_mem_addr 0; fetch_mem_req_rdy reads 1 once in IDLE.
REQ-030 Reset mid-operation SHALL discard partial data; no ack for the aborted request after release.

Verification
REQ-031 Single fetch addr 0x0000_1004, id 0x2A, ack_rdy=1 -> mem_addr 0x1000,0x1004,0x1008,0x100C on T+1..T+4; ack_vld at T+6, data {w3,w2,w1,w0}, id 0x2A, one cycle.
REQ-032 ack_rdy low 10 cycles in ACK -> ack_vld/data/id stable, req_rdy 0, inst_mem_en 0 throughout; handshake on rdy rise then IDLE.
REQ-033 req_vld held with ids 0x01 then 0x02 -> second accepted exactly one cycle after first ack handshake; ids returned in order.
REQ-034 Addr 0xFFFF_FFF8 -> mem_addr 0xFFFF_FFF0, F4, F8, FC; no wrap to 0x0.
REQ-035 rst_n asserted after 2 READ beats, released 3 cycles later -> all outputs 0 during reset, req_rdy 1 after, no ack_vld until a new request.
REQ-036 req_vld pulsed during READ -> not accepted, no extra inst_mem_en burst, ack carries original id.
